// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Observes a multiplexed 7-segment display bus and decodes it back to BCD.
// Each digit's dwell (segment pattern + one-hot digit select) must be seen
// unchanged for STABLE_CYCLES consecutive registered samples before it is
// committed. When every digit position has been committed at least once, a
// one-cycle frame_valid pulse is raised together with frame_err.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   seg[6:0]    in   segment lines, active-high, bit6=a .. bit0=g
//   dig_sel     in   one-hot digit select, bit i = digit i
//   digits      out  decoded BCD, digit i at [4i+3:4i] (E = illegal, F = blank)
//   blank       out  1 = digit i last committed as all-segments-off
//   frame_valid out  one-cycle pulse: all digits committed since last pulse
//   frame_err   out  qualified by frame_valid: an illegal pattern was seen
//   sel_err     out  one-cycle pulse: a registered dig_sel was nonzero, not one-hot
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    sel_err
);

  typedef enum logic {
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [7:0]            STABLE   = 8'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ALL_ONES = '1;

  // Registered input sample and the sample before it
  logic [6:0]            seg_q, seg_p;
  logic [NUM_DIGITS-1:0] sel_q, sel_p;
  logic [7:0]            cnt, cnt_n;

  state_t state, state_n;

  logic [NUM_DIGITS-1:0] mask, mask_n;
  logic                  acc;

  logic       sel_onehot;
  logic       sel_bad;
  logic       changed;
  logic       commit;
  logic [3:0] dec_val;
  logic       dec_blank;
  logic       dec_ill;

  // ---------------------------------------------------------------------------
  // Input stage and stability counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      sel_q <= '0;
      seg_p <= '0;
      sel_p <= '0;
      cnt   <= '0;
    end else begin
      seg_q <= seg;
      sel_q <= dig_sel;
      seg_p <= seg_q;
      sel_p <= sel_q;
      cnt   <= cnt_n;
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
    sel_bad    = (sel_q != '0) && !sel_onehot;
    changed    = (seg_q != seg_p) || (sel_q != sel_p);

    cnt_n = cnt;
    if (!sel_onehot || changed) begin
      cnt_n = 8'd1;
    end else if (cnt < STABLE) begin
      cnt_n = cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Dwell FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!sel_onehot) begin
      state_n = S_WAIT;
    end else begin
      case (state)
        S_WAIT:  if (cnt_n == STABLE) state_n = S_HOLD;
        S_HOLD:  if (changed)         state_n = S_WAIT;
        default: state_n = S_WAIT;
      endcase
    end
  end

  // A dwell commits once, on the edge where its count reaches STABLE; HOLD
  // suppresses repeats while the same pattern stays on the bus.
  always_comb begin
    commit = (state == S_WAIT) && sel_onehot && (cnt_n == STABLE);
  end

  // ---------------------------------------------------------------------------
  // Segment pattern decode
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_val   = 4'hE;
    dec_blank = 1'b0;
    dec_ill   = 1'b0;
    case (seg_q)
      7'b1111110: dec_val = 4'd0;
      7'b0110000: dec_val = 4'd1;
      7'b1101101: dec_val = 4'd2;
      7'b1111001: dec_val = 4'd3;
      7'b0110011: dec_val = 4'd4;
      7'b1011011: dec_val = 4'd5;
      7'b1011111: dec_val = 4'd6;
      7'b1110010: dec_val = 4'd7;
      7'b1111111: dec_val = 4'd8;
      7'b1111011: dec_val = 4'd9;
      7'b0000000: begin
        dec_val   = 4'hF;
        dec_blank = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Commit and frame assembly
  // ---------------------------------------------------------------------------
  always_comb begin
    mask_n = mask | sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      blank       <= '1;
      mask        <= '0;
      acc         <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      sel_err     <= sel_bad;
      if (commit) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel_q[i]) begin
            digits[4*i +: 4] <= dec_val;
            blank[i]         <= dec_blank;
          end
        end
        // The completing commit's own illegal flag is folded in directly,
        // since the accumulator is cleared on this same edge.
        if (mask_n == ALL_ONES) begin
          frame_valid <= 1'b1;
          frame_err   <= acc | dec_ill;
          mask        <= '0;
          acc         <= 1'b0;
        end else begin
          mask <= mask_n;
          acc  <= acc | dec_ill;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Drives digit dwells onto the display bus. A small reference model tracks
// digit values, blank bits, frame mask and error accumulator; completed frames
// are pushed to a scoreboard queue and popped when the DUT pulses frame_valid.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic            clk;
  logic            rst_n;
  logic [6:0]      seg;
  logic [ND-1:0]   dig_sel;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   blank;
  logic            frame_valid;
  logic            frame_err;
  logic            sel_err;

  seg_scan_decoder #(
    .NUM_DIGITS   (ND),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .digits     (digits),
    .blank      (blank),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .sel_err    (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4*ND-1:0] d;
    logic [ND-1:0]   b;
    logic            e;
  } frame_t;

  frame_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [4*ND-1:0] m_digits;
  logic [ND-1:0]   m_blank;
  logic [ND-1:0]   m_mask;
  logic            m_acc;
  int              exp_sel_err = 0;
  int              got_sel_err = 0;
  int              exp_frames  = 0;
  int              got_frames  = 0;

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110010,
                               7'b1111111, 7'b1111011};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_decode(input logic [6:0] p, output logic [3:0] v,
                                       output logic b, output logic ill);
    v   = 4'hE;
    b   = 1'b0;
    ill = 1'b1;
    if (p == 7'b0000000) begin
      v   = 4'hF;
      b   = 1'b1;
      ill = 1'b0;
    end else begin
      for (int k = 0; k < 10; k++) begin
        if (seg_tab[k] == p) begin
          v   = 4'(k);
          ill = 1'b0;
        end
      end
    end
  endfunction

  task automatic model_reset();
    m_digits = '0;
    m_blank  = '1;
    m_mask   = '0;
    m_acc    = 1'b0;
  endtask

  // One dwell of len cycles on digit idx; checks the field changes exactly on
  // edge SC+1 of the dwell when the dwell is long enough to commit.
  task automatic dwell(input int idx, input logic [6:0] pat, input int len);
    logic [3:0] v;
    logic [3:0] old_v;
    logic       b;
    logic       ill;
    bit         commits;
    frame_t     f;
    @(negedge clk);
    seg          = pat;
    dig_sel      = '0;
    dig_sel[idx] = 1'b1;
    commits = (len >= SC);
    old_v   = m_digits[4*idx +: 4];
    model_decode(pat, v, b, ill);
    if (commits) begin
      m_digits[4*idx +: 4] = v;
      m_blank[idx]         = b;
      m_mask[idx]          = 1'b1;
      m_acc                = m_acc | ill;
      if (m_mask == '1) begin
        f.d = m_digits;
        f.b = m_blank;
        f.e = m_acc;
        sb_q.push_back(f);
        exp_frames++;
        m_mask = '0;
        m_acc  = 1'b0;
      end
    end
    for (int k = 1; k <= len; k++) begin
      @(posedge clk);
      #1;
      if (k == SC)
        check($sformatf("pre_commit_d%0d", idx), 32'(digits[4*idx +: 4]), 32'(old_v));
      if (k == SC + 1 && commits)
        check($sformatf("commit_d%0d", idx), 32'(digits[4*idx +: 4]), 32'(v));
    end
  endtask

  task automatic bad_sel(input int n);
    @(negedge clk);
    dig_sel = 4'b0101;
    seg     = 7'b0110000;
    repeat (n) @(posedge clk);
    exp_sel_err += n;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h0);
    check({tag, "_blank"}, 32'(blank), 32'hF);
    check({tag, "_fvalid"}, 32'(frame_valid), 32'h0);
    check({tag, "_ferr"}, 32'(frame_err), 32'h0);
    check({tag, "_selerr"}, 32'(sel_err), 32'h0);
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge
  initial begin : monitor
    frame_t f;
    forever begin
      @(negedge clk);
      if (sel_err) got_sel_err++;
      if (frame_valid) begin
        got_frames++;
        if (sb_q.size() == 0) begin
          check("frame_unexpected", 32'(frame_valid), 32'h0);
        end else begin
          f = sb_q.pop_front();
          check("frame_digits", 32'(digits), 32'(f.d));
          check("frame_blank", 32'(blank), 32'(f.b));
          check("frame_err", 32'(frame_err), 32'(f.e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    rst_n   = 1'b0;
    seg     = '0;
    dig_sel = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Plain frame 1,2,3,4
    dwell(0, seg_tab[1], 6);
    dwell(1, seg_tab[2], 6);
    dwell(2, seg_tab[3], 6);
    dwell(3, seg_tab[4], 6);
    check("frame1_digits", 32'(digits), 32'h4321);
    check("frame1_blank", 32'(blank), 32'h0);

    // Short dwell of 8 on digit 2 must not commit
    dwell(0, seg_tab[5], 6);
    dwell(1, seg_tab[6], 6);
    dwell(2, seg_tab[8], 3);
    check("short_dwell_keep", 32'(digits[11:8]), 32'h3);
    dwell(3, seg_tab[7], 6);
    check("short_no_frame", 32'(got_frames), 32'd1);
    dwell(2, seg_tab[9], 6);
    check("frame2_digits", 32'(digits), 32'h7965);

    // Blank and illegal patterns in one frame, then a clean frame
    dwell(0, seg_tab[5], 6);
    dwell(1, 7'b0000000, 6);
    dwell(2, seg_tab[2], 6);
    dwell(3, 7'b1000001, 6);
    check("illegal_digits", 32'(digits), 32'hE2F5);
    check("illegal_blank", 32'(blank), 32'b0010);
    dwell(0, seg_tab[0], 6);
    dwell(1, seg_tab[1], 6);
    dwell(2, seg_tab[2], 6);
    dwell(3, seg_tab[3], 6);
    check("clean_digits", 32'(digits), 32'h3210);

    // Non-one-hot select interrupting a dwell
    dwell(0, seg_tab[4], 6);
    dwell(1, seg_tab[5], 2);
    bad_sel(2);
    dwell(1, seg_tab[5], 6);
    check("sel_err_pulses", 32'(got_sel_err), 32'd2);
    dwell(2, seg_tab[6], 6);
    dwell(3, seg_tab[7], 6);

    // Reset in the middle of a frame discards partial progress
    dwell(0, seg_tab[1], 6);
    dwell(1, seg_tab[2], 6);
    @(negedge clk);
    rst_n   = 1'b0;
    dig_sel = '0;
    seg     = '0;
    model_reset();
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    dwell(0, seg_tab[5], 6);
    dwell(1, seg_tab[6], 6);
    dwell(2, seg_tab[7], 6);
    dwell(3, seg_tab[8], 6);
    check("post_reset_digits", 32'(digits), 32'h8765);

    // Long hold on digit 0 commits once; frame needs the other three
    dwell(0, seg_tab[9], 20);
    check("hold_no_frame", 32'(sb_q.size()), 32'd0);
    dwell(1, seg_tab[1], 6);
    dwell(2, seg_tab[2], 6);
    dwell(3, seg_tab[3], 6);
    check("hold_digits", 32'(digits), 32'h3219);

    @(negedge clk);
    dig_sel = '0;
    seg     = '0;
    repeat (10) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("frame_count", 32'(got_frames), 32'(exp_frames));
    check("sel_err_total", 32'(got_sel_err), 32'(exp_sel_err));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reader side of the team's BCD-to-7-segment display path: observes a multiplexed 7-segment display bus (segment lines plus one-hot digit select), waits for each digit's dwell to be stable, and decodes the pattern back to BCD.
- Reassembles one full frame of NUM_DIGITS digits and flags it with a one-cycle valid pulse.
- Used for display loopback checking and for capturing panel contents into logic.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (2..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a dwell is committed (2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg  input  7  segment lines, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- dig_sel  input  NUM_DIGITS  active-high digit select; exactly one bit set selects a digit, bit i = digit i.
- digits  output  4*NUM_DIGITS  decoded BCD; digit i at bits [4i+3:4i].
- blank  output  NUM_DIGITS  1 = digit i last committed as all-segments-off.
- frame_valid  output  1  one-cycle pulse: every digit committed at least once since the previous pulse.
- frame_err  output  1  qualified by frame_valid; 1 = some commit in this frame was an illegal pattern.
- sel_err  output  1  one-cycle pulse: a registered dig_sel sample was nonzero and not one-hot.

Behaviour:
- Reset (asynchronous, active-low):
  - digits=0, blank=all 1, frame_valid=0, frame_err=0, sel_err=0.
  - Update mask, error accumulator, stability counter and input registers cleared.
  - FSM goes to WAIT.
  - Reset asserted mid-dwell or mid-frame discards all partial progress.
- Input stage: seg and dig_sel are registered every cycle into seg_q/sel_q. All decisions use registered values.
- Stability counter cnt, saturating at STABLE_CYCLES:
  - cnt=1 when (seg_q,sel_q) differs from the previous sample, or when sel_q is not one-hot.
  - Otherwise cnt increments.
- FSM:
  - WAIT: when sel_q is one-hot and the sample makes cnt reach STABLE_CYCLES, commit on that same edge and go to HOLD.
  - HOLD: stay while the sample is unchanged (no repeat commits). Any change goes to WAIT with cnt=1.
  - An invalid (not one-hot) sel_q forces WAIT in either state.
- Decode table (seg_q to value):
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110010=7, 1111111=8, 1111011=9.
  - 0000000 = blank: digit value 4'hF, blank bit set.
  - Any other pattern is illegal: digit value 4'hE, blank bit clear, error accumulator set.
  - A legal digit clears the blank bit.
- Commit: writes the digits field and blank bit of the selected digit and sets its mask bit.
  - A repeat commit to an already-masked digit within a frame overwrites the value; the mask is unchanged.
- Latency: seg/dig_sel constant and valid from before edge E1 → digits updated after edge E(STABLE_CYCLES+1).
- Frame completion: on the commit edge that makes the mask all-ones:
  - frame_valid=1 for exactly one cycle.
  - frame_err = accumulator OR'd with the current commit's illegal flag.
  - Mask and accumulator are cleared on that same edge.
  - digits and blank hold until overwritten by later commits.
- sel_err: pulses on the edge after sel_q is nonzero and not one-hot. All-zero sel_q is idle: no pulse, forces WAIT.
- Dwell shorter than STABLE_CYCLES samples: ignored, no state change beyond the counter.
- Illegal digit codes 10..15 cannot appear as outputs except 4'hE (illegal) and 4'hF (blank).

Test Plan:
- NUM_DIGITS=4, STABLE_CYCLES=4; scan digits 0..3 with patterns for 1,2,3,4, 6 cycles each:
  - Required: digits=16'h4321 after the 4th commit, frame_valid one pulse, frame_err=0, blank=4'b0000.
  - Each digit field updates exactly 5 cycles after its dwell starts.
- Dwell of 3 cycles on digit 2 showing 1111111, then return to the normal scan:
  - Required: no commit of 8; digit 2 keeps its prior value; frame_valid is delayed until digit 2 has a full-length dwell.
- Digit 1 shows 0000000 and digit 3 shows 1000001 in one frame:
  - Required: blank=4'b0010, digits[7:4]=F, digits[15:12]=E, frame_err=1 with frame_valid.
  - The next clean frame reports frame_err=0.
- dig_sel=4'b0101 for 2 cycles during a dwell:
  - Required: one sel_err pulse per bad sample (2 pulses); cnt restarts.
  - The following valid dwell commits 5 cycles after it begins.
- Assert rst_n=0 after 2 digits have committed, then release and scan a full frame 5,6,7,8:
  - Required: all outputs at reset values during reset.
  - First frame_valid only after all 4 new commits; digits=16'h8765.
- Hold digit 0 showing 9 for 20 cycles:
  - Required: a single commit (HOLD state); no frame_valid until digits 1..3 are also committed.
